// File: rtl/debounce_sync.sv
// debounce_sync: synchronises a raw asynchronous level into clk, rejects
// bounce shorter than a programmable stability window and delivers a clean
// registered level plus single-cycle rise/fall pulses.
//
// Ports
//   clk    in   clock, all logic on posedge
//   reset  in   synchronous active-low reset
//   din    in   raw asynchronous input
//   en     in   count enable / tick for the qualification counter
//   q      out  debounced level (registered)
//   rise   out  one-cycle pulse coincident with q 0->1
//   fall   out  one-cycle pulse coincident with q 1->0
//   busy   out  high while a candidate transition is being qualified
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   q_nxt, rise_nxt, fall_nxt;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   s;

  // Synchroniser chain: din enters at bit 0, s is the last stage.
  always_ff @(posedge clk) begin
    if (!reset) sync_pipe <= {SYNC_STAGES{INIT_LEVEL}};
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
  end

  assign s = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
      cnt   <= '0;
      q     <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // A bounce aborts a WAIT regardless of en; en only gates counting.
  // Counter tops out at STABLE_CYCLES-1, so it can never wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (en) begin
          if (cnt == CNT_LAST) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
            q_nxt     = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (en) begin
          if (cnt == CNT_LAST) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
            q_nxt     = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Decoded straight from the state register, so it is registered with state.
  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

  logic clk = 1'b0;
  logic reset = 1'b0, din = 1'b0, en = 1'b1;
  logic rst1 = 1'b0, din1 = 1'b1;
  logic q, rise, fall, busy;
  logic q1, rise1, fall1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_sync u0 (
    .clk(clk), .reset(reset), .din(din), .en(en),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  debounce_sync #(.INIT_LEVEL(1'b1)) u1 (
    .clk(clk), .reset(rst1), .din(din1), .en(en),
    .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  // One row = inputs applied before an edge, outputs {q,rise,fall,busy}
  // expected just after that edge.
  typedef struct {
    logic       rst;
    logic       d;
    logic       e;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic e,
                     input logic [3:0] exp, input string nm);
    vec_t v;
    v.rst = r; v.d = d; v.e = e; v.exp = exp; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] qrfb got %b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic step0(input logic r, input logic d, input logic e);
    reset = r; din = d; en = e;
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic r, input logic d);
    rst1 = r; din1 = d;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with din=1, then release and qualify the high level.
    add(0, 1, 1, 4'b0000, "rst_hold");
    add(0, 1, 1, 4'b0000, "rst_hold");
    add(1, 1, 1, 4'b0000, "rst_rel");
    add(1, 1, 1, 4'b0000, "rst_rel");
    add(1, 1, 1, 4'b0001, "rst_rel");
    add(1, 1, 1, 4'b0001, "rst_rel");
    add(1, 1, 1, 4'b0001, "rst_rel");
    add(1, 1, 1, 4'b0001, "rst_rel");
    add(1, 1, 1, 4'b1100, "rst_rel");
    add(1, 1, 1, 4'b1000, "rst_rel");
    // Clean release from STABLE_HI.
    add(1, 0, 1, 4'b1000, "clean_fall");
    add(1, 0, 1, 4'b1000, "clean_fall");
    add(1, 0, 1, 4'b1001, "clean_fall");
    add(1, 0, 1, 4'b1001, "clean_fall");
    add(1, 0, 1, 4'b1001, "clean_fall");
    add(1, 0, 1, 4'b1001, "clean_fall");
    add(1, 0, 1, 4'b0010, "clean_fall");
    add(1, 0, 1, 4'b0000, "clean_fall");
    // Three-cycle bounce in STABLE_LO: cnt reaches 2 only, then aborts.
    add(1, 1, 1, 4'b0000, "bounce");
    add(1, 1, 1, 4'b0000, "bounce");
    add(1, 1, 1, 4'b0001, "bounce");
    add(1, 0, 1, 4'b0001, "bounce");
    add(1, 0, 1, 4'b0001, "bounce");
    add(1, 0, 1, 4'b0000, "bounce");
    add(1, 0, 1, 4'b0000, "bounce");
    // en every other cycle: counting happens only on the en=1 edges.
    add(1, 1, 1, 4'b0000, "en_gate");
    add(1, 1, 0, 4'b0000, "en_gate");
    add(1, 1, 1, 4'b0001, "en_gate");
    add(1, 1, 0, 4'b0001, "en_gate");
    add(1, 1, 1, 4'b0001, "en_gate");
    add(1, 1, 0, 4'b0001, "en_gate");
    add(1, 1, 1, 4'b0001, "en_gate");
    add(1, 1, 0, 4'b0001, "en_gate");
    add(1, 1, 1, 4'b0001, "en_gate");
    add(1, 1, 0, 4'b0001, "en_gate");
    add(1, 1, 1, 4'b1100, "en_gate");
    add(1, 1, 0, 4'b1000, "en_gate");

    // Initial sample taken while reset is asserted and no edge yet seen
    // by the logic driving u1 (it is held in reset the whole time).
    for (int i = 0; i < vecs.size(); i++) begin
      step0(vecs[i].rst, vecs[i].d, vecs[i].e);
      chk(vecs[i].nm, i, {q, rise, fall, busy}, vecs[i].exp);
    end

    // Reset arriving on the very edge that would complete WAIT_HI.
    step0(0, 0, 1); chk("mid_rst", 0, {q, rise, fall, busy}, 4'b0000);
    step0(0, 0, 1); chk("mid_rst", 1, {q, rise, fall, busy}, 4'b0000);
    step0(1, 1, 1); chk("mid_rst", 2, {q, rise, fall, busy}, 4'b0000);
    step0(1, 1, 1); chk("mid_rst", 3, {q, rise, fall, busy}, 4'b0000);
    step0(1, 1, 1); chk("mid_rst", 4, {q, rise, fall, busy}, 4'b0001);
    step0(1, 1, 1); chk("mid_rst", 5, {q, rise, fall, busy}, 4'b0001);
    step0(1, 1, 1); chk("mid_rst", 6, {q, rise, fall, busy}, 4'b0001);
    step0(1, 1, 1); chk("mid_rst", 7, {q, rise, fall, busy}, 4'b0001);
    step0(0, 1, 1); chk("mid_rst", 8, {q, rise, fall, busy}, 4'b0000);
    step0(0, 1, 1); chk("mid_rst", 9, {q, rise, fall, busy}, 4'b0000);

    // INIT_LEVEL=1 instance: din=1 through reset, then a 1-cycle low glitch.
    en = 1'b1;
    step1(0, 1); chk("init1_rst", 0, {q1, rise1, fall1, busy1}, 4'b1000);
    step1(0, 1); chk("init1_rst", 1, {q1, rise1, fall1, busy1}, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      step1(1, 1); chk("init1_rel", i, {q1, rise1, fall1, busy1}, 4'b1000);
    end
    step1(1, 0); chk("init1_glitch", 0, {q1, rise1, fall1, busy1}, 4'b1000);
    step1(1, 1); chk("init1_glitch", 1, {q1, rise1, fall1, busy1}, 4'b1000);
    step1(1, 1); chk("init1_glitch", 2, {q1, rise1, fall1, busy1}, 4'b1001);
    for (int i = 3; i < 10; i++) begin
      step1(1, 1); chk("init1_glitch", i, {q1, rise1, fall1, busy1}, 4'b1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
